// File: rtl/fare_pkg.sv
// Shared types and constants for the ticket/change dispensing arbiter.
package fare_pkg;

  // Default datapath widths and fare-machine limits.
  localparam int CNT_W       = 3;
  localparam int CHG_W       = 7;
  localparam int MAX_TICKETS = 5;

  // Coin denominations paid out by the change dispenser.
  localparam int COIN_BIG    = 5;
  localparam int COIN_SMALL  = 1;

  // Service sequencer states.
  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    PRINT,
    PWAIT,
    CHANGE,
    FINISH
  } state_t;

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational round-robin selector: first set req bit at or above rr_ptr,
// wrapping modulo NUM_REQ. Returns a one-hot pick and its binary index.
module rr_priority_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic [NUM_REQ-1:0] pick,
  output logic [IDX_W-1:0]   pick_idx,
  output logic               valid
);

  localparam int CW = IDX_W + 1;

  // Scan candidates rr_ptr, rr_ptr+1, ... and keep the first requester found.
  always_comb begin : scan
    logic [CW-1:0] cand;
    // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
    pick     = '0;
    pick_idx = '0;
    valid    = 1'b0;
    cand     = '0;
    for (int off = 0; off < NUM_REQ; off++) begin
      // NOTE: blocking assignments here because cand is a temporary reused within the same pass.
      cand = {1'b0, rr_ptr} + CW'(off);
      if (cand >= CW'(NUM_REQ)) begin
        cand = cand - CW'(NUM_REQ);
      end
      if (!valid && req[cand[IDX_W-1:0]]) begin
        valid                   = 1'b1;
        pick[cand[IDX_W-1:0]]   = 1'b1;
        pick_idx                = cand[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/ticket_dispense_arbiter.sv
// Shares one ticket printer and one coin dispenser between NUM_REQ fare
// front ends. Grants round-robin, prints one job per ticket, pays change
// as 5-unit coins then 1-unit coins, and pulses done to the served requester.
module ticket_dispense_arbiter
  import fare_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int CNT_W       = fare_pkg::CNT_W,
  parameter int CHG_W       = fare_pkg::CHG_W,
  parameter int MAX_TICKETS = fare_pkg::MAX_TICKETS
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*CNT_W-1:0] req_tickets,
  input  logic [NUM_REQ*CHG_W-1:0] req_change,
  output logic [NUM_REQ-1:0]       grant,
  output logic [NUM_REQ-1:0]       done,
  output logic                     err,
  output logic                     prn_start,
  input  logic                     prn_busy,
  output logic                     coin5,
  output logic                     coin1,
  output logic [CNT_W-1:0]         tickets_left
);

  localparam int IDX_W = $clog2(NUM_REQ);

  state_t               state_q, state_d;
  logic [IDX_W-1:0]     rr_ptr_q;
  logic [IDX_W-1:0]     gidx_q;
  logic [NUM_REQ-1:0]   grant_q;
  logic [CNT_W-1:0]     tickets_q;
  logic [CHG_W-1:0]     chg_q;
  logic                 err_flag_q;

  logic [NUM_REQ-1:0]   pick;
  logic [IDX_W-1:0]     pick_idx;
  logic                 pick_valid;
  logic                 ticket_illegal;
  logic                 take_grant;

  rr_priority_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req      (req),
    .rr_ptr   (rr_ptr_q),
    .pick     (pick),
    .pick_idx (pick_idx),
    .valid    (pick_valid)
  );

  // A zero count or one above the machine limit is rejected without printing or paying.
  assign ticket_illegal = (tickets_q == '0) || (int'(tickets_q) > MAX_TICKETS);
  assign take_grant     = (state_q == IDLE) && pick_valid;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: non-blocking assignments in clocked blocks so every register samples pre-edge values.
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode and the single-cycle pulses driven from the current state.
  always_comb begin
    state_d   = state_q;
    prn_start = 1'b0;
    coin5     = 1'b0;
    coin1     = 1'b0;
    done      = '0;
    err       = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          state_d = CHECK;
        end
      end
      CHECK: begin
        state_d = ticket_illegal ? FINISH : PRINT;
      end
      PRINT: begin
        if (!prn_busy) begin
          prn_start = 1'b1;
          state_d   = PWAIT;
        end
      end
      PWAIT: begin
        // The printer reports busy from the cycle after prn_start, so this waits for the job.
        if (!prn_busy) begin
          state_d = (tickets_q != '0) ? PRINT : CHANGE;
        end
      end
      CHANGE: begin
        if (chg_q >= CHG_W'(COIN_BIG)) begin
          coin5 = 1'b1;
        end else if (chg_q != '0) begin
          coin1 = 1'b1;
        end else begin
          state_d = FINISH;
        end
      end
      FINISH: begin
        done    = grant_q;
        err     = err_flag_q;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Grant ownership and round-robin pointer; pointer moves past the served requester.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grant_q  <= '0;
      gidx_q   <= '0;
      rr_ptr_q <= '0;
    end else if (take_grant) begin
      grant_q <= pick;
      gidx_q  <= pick_idx;
    end else if (state_q == FINISH) begin
      grant_q  <= '0;
      rr_ptr_q <= (gidx_q == IDX_W'(NUM_REQ - 1)) ? '0 : gidx_q + 1'b1;
    end
  end

  // Service datapath: inputs are latched once at grant and then only counted down.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tickets_q  <= '0;
      chg_q      <= '0;
      err_flag_q <= 1'b0;
    end else begin
      if (take_grant) begin
        tickets_q  <= req_tickets[int'(pick_idx)*CNT_W +: CNT_W];
        chg_q      <= req_change[int'(pick_idx)*CHG_W +: CHG_W];
        err_flag_q <= 1'b0;
      end
      if (state_q == CHECK) begin
        err_flag_q <= ticket_illegal;
      end
      if (prn_start) begin
        tickets_q <= tickets_q - CNT_W'(1);
      end
      if (coin5) begin
        chg_q <= chg_q - CHG_W'(COIN_BIG);
      end else if (coin1) begin
        chg_q <= chg_q - CHG_W'(COIN_SMALL);
      end
    end
  end

  assign grant        = grant_q;
  assign tickets_left = tickets_q;

endmodule
